apb_timer_multi: RTL and testbench



---
 rtl/apb_timer_multi.sv | 182 ++++++++++++++++++
 tb/tb_apb_timer_multi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_multi.sv
// apb_timer_multi: NUM_CH independent prescaled up-counters behind an APB slave.
// Each channel has CNT, CMP, CTRL (EN/ONESHOT/PRESC) and a W1C STATUS.PEND level irq.
// Optional macro TIMER_CASCADE_EN: odd channels may tick on the previous channel's match.
module apb_timer_multi #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned PRESC_WIDTH    = 8,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [NUM_CH-1:0]         irq_o
);

    localparam logic [31:0] IrqStatusAddr = 32'h0000_0100;
    localparam logic [31:0] EnSetAddr     = 32'h0000_0104;

    logic [CNT_WIDTH-1:0]   r_cnt   [NUM_CH];
    logic [CNT_WIDTH-1:0]   r_cmp   [NUM_CH];
    logic [PRESC_WIDTH-1:0] r_presc [NUM_CH];
    logic [PRESC_WIDTH-1:0] r_pc    [NUM_CH];
    logic [NUM_CH-1:0]      r_en, r_oneshot, r_pend;

    logic [CNT_WIDTH-1:0]   w_cnt_d   [NUM_CH];
    logic [CNT_WIDTH-1:0]   w_cmp_d   [NUM_CH];
    logic [PRESC_WIDTH-1:0] w_presc_d [NUM_CH];
    logic [PRESC_WIDTH-1:0] w_pc_d    [NUM_CH];
    logic [NUM_CH-1:0]      w_en_d, w_oneshot_d, w_pend_d;

`ifdef TIMER_CASCADE_EN
    logic [NUM_CH-1:0]      r_casc, w_casc_d;
    logic [NUM_CH-1:0]      w_prev_match;
`endif

    logic [31:0]       w_addr;
    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic              w_chan_rgn, w_wr, w_en_set, w_mapped;
    logic [NUM_CH-1:0] w_base_tick, w_base_match, w_tick, w_match, w_sel;

    assign w_addr     = 32'(PADDR) & 32'hFFFF_FFFC;
    assign w_ch       = w_addr[7:4];
    assign w_reg      = w_addr[3:2];
    assign w_chan_rgn = (w_addr[31:8] == 24'h0) && (32'(w_ch) < NUM_CH);
    assign w_wr       = PSEL && PENABLE && PWRITE;
    assign w_en_set   = w_wr && (w_addr == EnSetAddr);

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL && PENABLE && !w_mapped;
    assign irq_o   = r_pend;

    // Read mux and address decode; PRDATA follows PADDR combinationally.
    always_comb begin
        PRDATA   = '0;
        w_mapped = 1'b0;
        if (w_chan_rgn) begin
            w_mapped = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(w_ch) == i) begin
                    case (w_reg)
                        2'd0: PRDATA = 32'(r_cnt[i]);
                        2'd1: PRDATA = 32'(r_cmp[i]);
                        2'd2: begin
                            PRDATA[0] = r_en[i];
                            PRDATA[1] = r_oneshot[i];
`ifdef TIMER_CASCADE_EN
                            PRDATA[2] = r_casc[i];
`endif
                            PRDATA[8 +: PRESC_WIDTH] = r_presc[i];
                        end
                        default: PRDATA[0] = r_pend[i];
                    endcase
                end
            end
        end else if (w_addr == IrqStatusAddr) begin
            w_mapped = 1'b1;
            PRDATA   = 32'(r_pend);
        end else if (w_addr == EnSetAddr) begin
            w_mapped = 1'b1;
        end
    end

    // Prescaler-driven tick and match for every channel, ignoring cascade.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_base_tick[i]  = r_en[i] && (r_pc[i] == r_presc[i]);
            w_base_match[i] = w_base_tick[i] && (r_cnt[i] == r_cmp[i]);
        end
    end

`ifdef TIMER_CASCADE_EN
    assign w_prev_match = w_base_match << 1;
`endif

    // Per-channel next state: APB writes, counting, match handling.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]   = w_wr && w_chan_rgn && (int'(w_ch) == i);
            w_tick[i]  = w_base_tick[i];
`ifdef TIMER_CASCADE_EN
            // r_casc is only ever set on odd channels.
            if (r_casc[i]) w_tick[i] = r_en[i] && w_prev_match[i];
            w_casc_d[i] = r_casc[i];
`endif
            w_match[i] = w_tick[i] && (r_cnt[i] == r_cmp[i]);

            w_cnt_d[i]     = r_cnt[i];
            w_cmp_d[i]     = r_cmp[i];
            w_presc_d[i]   = r_presc[i];
            w_pc_d[i]      = r_pc[i];
            w_en_d[i]      = r_en[i];
            w_oneshot_d[i] = r_oneshot[i];
            w_pend_d[i]    = r_pend[i];

            if (r_en[i]) w_pc_d[i] = w_base_tick[i] ? '0 : r_pc[i] + 1'b1;

            if (w_match[i]) begin
                w_cnt_d[i] = '0;
                if (r_oneshot[i]) w_en_d[i] = 1'b0;
            end else if (w_tick[i]) begin
                w_cnt_d[i] = r_cnt[i] + 1'b1;
            end

            if (w_sel[i]) begin
                case (w_reg)
                    2'd0: w_cnt_d[i] = PWDATA[CNT_WIDTH-1:0];
                    2'd1: w_cmp_d[i] = PWDATA[CNT_WIDTH-1:0];
                    2'd2: begin
                        w_en_d[i]      = PWDATA[0];
                        w_oneshot_d[i] = PWDATA[1];
                        w_presc_d[i]   = PWDATA[8 +: PRESC_WIDTH];
                        w_pc_d[i]      = '0;
`ifdef TIMER_CASCADE_EN
                        w_casc_d[i]    = PWDATA[2] && ((i % 2) == 1);
`endif
                    end
                    default: if (PWDATA[0]) w_pend_d[i] = 1'b0;
                endcase
            end

            if (w_en_set && PWDATA[i]) w_en_d[i] = 1'b1;
            // A match in the same cycle as a W1C keeps PEND set.
            if (w_match[i]) w_pend_d[i] = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt     <= '{default: '0};
            r_cmp     <= '{default: '0};
            r_presc   <= '{default: '0};
            r_pc      <= '{default: '0};
            r_en      <= '0;
            r_oneshot <= '0;
            r_pend    <= '0;
`ifdef TIMER_CASCADE_EN
            r_casc    <= '0;
`endif
        end else begin
            r_cnt     <= w_cnt_d;
            r_cmp     <= w_cmp_d;
            r_presc   <= w_presc_d;
            r_pc      <= w_pc_d;
            r_en      <= w_en_d;
            r_oneshot <= w_oneshot_d;
            r_pend    <= w_pend_d;
`ifdef TIMER_CASCADE_EN
            r_casc    <= w_casc_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_timer_multi.sv
// Testbench for apb_timer_multi: directed steps plus randomized channel runs
// checked against a closed-form model of count value, PEND and EN versus elapsed cycles.
module tb_apb_timer_multi;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  irq_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    apb_timer_multi #(
        .NUM_CH(4), .CNT_WIDTH(32), .PRESC_WIDTH(8), .APB_ADDR_WIDTH(12)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .irq_o(irq_o)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle index of the access edge in t.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output int t);
        @(negedge HCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(posedge HCLK);
        #1;
        t = cyc;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        int t;
        apb_write(a, d, t);
    endtask

    // Samples in the access phase; s = number of clock edges seen so far.
    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e,
                            output logic [3:0] irq, output int s);
        @(negedge HCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        d = PRDATA; e = PSLVERR; irq = irq_o; s = cyc;
        @(posedge HCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Model: k cycles after EN written, with CMP=c, PRESC=p.
    function automatic logic [31:0] exp_cnt(input int k, input int c, input int p, input int os);
        int l;
        l = (c + 1) * (p + 1);
        if (os != 0 && k >= l) return 32'h0;
        return 32'((k / (p + 1)) % (c + 1));
    endfunction

    function automatic logic exp_pend(input int k, input int c, input int p);
        return k >= (c + 1) * (p + 1);
    endfunction

    function automatic logic [31:0] exp_ctrl(input int k, input int c, input int p, input int os);
        logic en;
        en = (os == 0) || (k < (c + 1) * (p + 1));
        return 32'((p << 8) | (os << 1) | int'(en));
    endfunction

    task automatic start_chan(input int ch, input int c, input int p, input int os,
                              output int t0);
        logic [11:0] b;
        b = 12'(ch * 16);
        wr(b + 12'h8, 32'h0);
        wr(b + 12'h0, 32'h0);
        wr(b + 12'hC, 32'h1);
        wr(b + 12'h4, 32'(c));
        apb_write(b + 12'h8, 32'((p << 8) | (os << 1) | 1), t0);
    endtask

    task automatic stop_chan(input int ch);
        wr(12'(ch * 16 + 8), 32'h0);
        wr(12'(ch * 16 + 12), 32'h1);
    endtask

    task automatic run_model(input int ch, input int c, input int p, input int os,
                             input int t0, input int horizon);
        logic [31:0] d;
        logic        e;
        logic [3:0]  irq;
        int          s;
        int          k;
        logic [11:0] b;
        b = 12'(ch * 16);
        k = 0;
        while (k <= horizon) begin
            repeat ($urandom_range(0, 2)) @(posedge HCLK);
            apb_read(b, d, e, irq, s);
            k = s - t0;
            check($sformatf("ch%0d cnt k=%0d", ch, k), d, exp_cnt(k, c, p, os));
            check($sformatf("ch%0d irq k=%0d", ch, k), 32'(irq[ch]), 32'(exp_pend(k, c, p)));
            apb_read(b + 12'hC, d, e, irq, s);
            k = s - t0;
            check($sformatf("ch%0d status k=%0d", ch, k), d, 32'(exp_pend(k, c, p)));
            apb_read(b + 12'h8, d, e, irq, s);
            k = s - t0;
            check($sformatf("ch%0d ctrl k=%0d", ch, k), d, exp_ctrl(k, c, p, os));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] ev;
        logic        e;
        logic [3:0]  irq;
        int          s;
        int          t;
        int          t2;
        int          k;

        // Reset values.
        #1;
        check("rst irq", 32'(irq_o), 32'h0);
        check("rst prdata", PRDATA, 32'h0);
        check("rst pslverr", 32'(PSLVERR), 32'h0);
        check("rst pready", 32'(PREADY), 32'h1);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(12'(ch * 16 + r * 4), d, e, irq, s);
                check($sformatf("rst rd ch%0d r%0d", ch, r), d, 32'h0);
                check($sformatf("rst err ch%0d r%0d", ch, r), 32'(e), 32'h0);
            end
        end
        apb_read(12'h100, d, e, irq, s);
        check("rst irq_status", d, 32'h0);
        apb_read(12'h104, d, e, irq, s);
        check("rst en_set rd", d, 32'h0);
        check("rst en_set err", 32'(e), 32'h0);
        apb_read(12'h200, d, e, irq, s);
        check("unmapped 0x200 err", 32'(e), 32'h1);
        check("unmapped 0x200 data", d, 32'h0);
        apb_read(12'h040, d, e, irq, s);
        check("unmapped ch4 err", 32'(e), 32'h1);
        check("unmapped ch4 data", d, 32'h0);

        // Ch0 continuous, CMP=9, PRESC=0: rise 10 cycles after CTRL write.
        wr(12'h004, 32'd9);
        apb_write(12'h008, 32'h1, t);
        PADDR = 12'h000;
        for (int n = 1; n <= 10; n++) begin
            @(posedge HCLK);
            #1;
            k = cyc - t;
            check($sformatf("ch0 irq k=%0d", k), 32'(irq_o[0]), 32'(k >= 10));
            check($sformatf("ch0 cnt k=%0d", k), PRDATA, 32'(k % 10));
        end
        apb_write(12'h00C, 32'h1, t2);
        check("ch0 w1c irq", 32'(irq_o[0]), 32'h0);
        PADDR = 12'h000;
        while (cyc < t + 20) begin
            @(posedge HCLK);
            #1;
            k = cyc - t;
            check($sformatf("ch0 2nd irq k=%0d", k), 32'(irq_o[0]), 32'(k >= 20));
            check($sformatf("ch0 2nd cnt k=%0d", k), PRDATA, 32'(k % 10));
        end
        stop_chan(0);

        // Ch1 one-shot, CMP=3, PRESC=4: match at 20, then held.
        start_chan(1, 3, 4, 1, t);
        for (int n = 1; n <= 21; n++) begin
            @(posedge HCLK);
            #1;
            k = cyc - t;
            check($sformatf("ch1 os irq k=%0d", k), 32'(irq_o[1]), 32'(k >= 20));
        end
        run_model(1, 3, 4, 1, t, 120);
        stop_chan(1);

        // Ch2 wrap: starts at 0xFFFF_FFFE, CMP=5.
        wr(12'h028, 32'h0);
        wr(12'h02C, 32'h1);
        wr(12'h020, 32'hFFFF_FFFE);
        wr(12'h024, 32'd5);
        apb_write(12'h028, 32'h1, t);
        PADDR = 12'h020;
        for (int n = 1; n <= 10; n++) begin
            @(posedge HCLK);
            #1;
            k = cyc - t;
            ev = (k < 8) ? 32'hFFFF_FFFE + 32'(k) : 32'(k - 8);
            check($sformatf("ch2 wrap cnt k=%0d", k), PRDATA, ev);
            check($sformatf("ch2 wrap irq k=%0d", k), 32'(irq_o[2]), 32'(k >= 8));
        end
        stop_chan(2);

        // Randomized channel runs against the model.
        for (int it = 0; it < 8; it++) begin
            int ch, c, p, os;
            ch = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 6));
            p  = int'($urandom_range(0, 3));
            os = int'($urandom_range(0, 1));
            start_chan(ch, c, p, os, t);
            run_model(ch, c, p, os, t, 2 * (c + 1) * (p + 1) + 6);
            stop_chan(ch);
        end

        // Ch3: CNT write against a tick, then W1C against a match.
        start_chan(3, 32'hFFFF, 0, 0, t);
        apb_write(12'h030, 32'h40, t2);
        check("ch3 cnt write wins", PRDATA, 32'h40);
        apb_read(12'h030, d, e, irq, s);
        check("ch3 cnt after write", d, 32'h40 + 32'(s - t2));
        wr(12'h034, 32'h0);
        wr(12'h030, 32'h0);
        apb_write(12'h03C, 32'h1, t2);
        check("ch3 w1c vs match irq", 32'(irq_o[3]), 32'h1);
        PADDR = 12'h030;
        for (int n = 0; n < 3; n++) begin
            @(posedge HCLK);
            #1;
            check($sformatf("ch3 cmp0 irq n=%0d", n), 32'(irq_o[3]), 32'h1);
            check($sformatf("ch3 cmp0 cnt n=%0d", n), PRDATA, 32'h0);
        end
        apb_read(12'h03C, d, e, irq, s);
        check("ch3 status set", d, 32'h1);
        stop_chan(3);
        check("ch3 cleared irq", 32'(irq_o[3]), 32'h0);

        // EN_SET starts ch0 with PRESC=1, CMP=2.
        wr(12'h008, 32'h0);
        wr(12'h000, 32'h0);
        wr(12'h00C, 32'h1);
        wr(12'h004, 32'd2);
        wr(12'h008, 32'h100);
        apb_write(12'h104, 32'h1, t);
        run_model(0, 2, 1, 0, t, 12);
        apb_read(12'h100, d, e, irq, s);
        check("irq_status", d, 32'(exp_pend(s - t, 2, 1)));
        apb_read(12'h104, d, e, irq, s);
        check("en_set reads 0", d, 32'h0);
        stop_chan(0);

`ifdef TIMER_CASCADE_EN
        // Cascade ch1 on ch0 matches: ch0 CMP=1, ch1 CMP=2.
        wr(12'h000, 32'h0);
        wr(12'h004, 32'd1);
        wr(12'h018, 32'h4);
        wr(12'h010, 32'h0);
        wr(12'h01C, 32'h1);
        wr(12'h014, 32'd2);
        apb_write(12'h104, 32'h3, t);
        for (int n = 1; n <= 7; n++) begin
            @(posedge HCLK);
            #1;
            k = cyc - t;
            check($sformatf("casc irq1 k=%0d", k), 32'(irq_o[1]), 32'(k >= 6));
        end
        apb_read(12'h018, d, e, irq, s);
        check("casc ctrl1", d, 32'h5);
        wr(12'h008, 32'h4);
        apb_read(12'h008, d, e, irq, s);
        check("casc even ctrl0", d, 32'h0);
        stop_chan(0);
        stop_chan(1);
`else
        wr(12'h018, 32'h4);
        apb_read(12'h018, d, e, irq, s);
        check("no cascade bit2", d, 32'h0);
`endif

        // Reset mid-count aborts the count and the pending irq.
        start_chan(0, 2, 0, 0, t);
        repeat (5) @(posedge HCLK);
        #1;
        check("pre-reset irq", 32'(irq_o[0]), 32'h1);
        @(negedge HCLK);
        PADDR = 12'h000;
        HRESETn = 1'b0;
        #1;
        check("midreset irq", 32'(irq_o), 32'h0);
        check("midreset cnt", PRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(posedge HCLK);
        apb_read(12'h000, d, e, irq, s);
        check("post-reset cnt held", d, 32'h0);
        apb_read(12'h008, d, e, irq, s);
        check("post-reset ctrl", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
